// File: rtl/covariance_accumulator_if.sv
// Sample-stream and covariance-matrix handshake bundle between the ECG front end
// and the eigen-decomposition stage.
interface covariance_accumulator_if #(
  parameter int SIZE_N = 8,
  parameter int DATA_W = 24,
  parameter int LOG2_M = 10
);
  localparam int ACC_W = 2*DATA_W + LOG2_M - 1;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_sample [SIZE_N];
  logic                     cov_valid;
  logic                     cov_ack;
  logic signed [ACC_W-1:0]  cov_mat [SIZE_N][SIZE_N];

  modport master (
    output in_valid, in_sample, cov_ack,
    input  in_ready, cov_valid, cov_mat
  );

  modport slave (
    input  in_valid, in_sample, cov_ack,
    output in_ready, cov_valid, cov_mat
  );
endinterface

// File: rtl/covariance_accumulator.sv
// Frame-based first/second moment accumulator producing the mean-removed,
// normalised covariance matrix for the PCA/ICA eigen stage.
module covariance_accumulator #(
  parameter int SIZE_N = 8,
  parameter int DATA_W = 24,
  parameter int LOG2_M = 10
) (
  input  logic clk,
  input  logic rst,
  covariance_accumulator_if.slave bus
);
  localparam int ACC_W  = 2*DATA_W + LOG2_M - 1;
  localparam int SUM_W  = DATA_W + LOG2_M;
  localparam int PROD_W = 2*SUM_W;
  localparam int NUM_T  = SIZE_N*(SIZE_N+1)/2;
  localparam int IDX_W  = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
  localparam int K_W    = $clog2(NUM_T+1);

  typedef enum logic [1:0] {ACCUM, FINAL, DONE} state_t;
  state_t state_reg, state_next;

  logic signed [SUM_W-1:0]    sum_reg [SIZE_N];
  logic signed [ACC_W-1:0]    sq_reg  [NUM_T];
  logic signed [2*DATA_W-1:0] prod    [NUM_T];
  logic signed [ACC_W-1:0]    cov_reg [SIZE_N][SIZE_N];
  logic [LOG2_M-1:0]          cnt_reg;

  logic [K_W-1:0]          k_reg;
  logic [IDX_W-1:0]        row_reg, col_reg;
  logic                    v1_reg, last1_reg;
  logic signed [SUM_W-1:0] a1_reg, b1_reg;
  logic signed [ACC_W-1:0] sq1_reg;
  logic [IDX_W-1:0]        row1_reg, col1_reg;
  logic                    v2_reg, last2_reg;
  logic signed [PROD_W-1:0] prod2_reg;
  logic signed [ACC_W-1:0] sq2_reg;
  logic [IDX_W-1:0]        row2_reg, col2_reg;

  logic accept, last_accept, last_write, clear;
  logic accepting, holding;
  logic signed [PROD_W-1:0] corr;
  logic signed [ACC_W-1:0]  diff, cov_val;

  assign accept      = bus.in_valid && (state_reg == ACCUM);
  assign last_accept = accept && (&cnt_reg);
  assign last_write  = v2_reg && last2_reg;
  assign clear       = (state_reg == DONE) && bus.cov_ack;

  // Upper-triangle products, flattened row-major so index k matches the FINAL walk.
  for (genvar gi = 0; gi < SIZE_N; gi++) begin : g_row
    for (genvar gj = gi; gj < SIZE_N; gj++) begin : g_col
      localparam int K = gi*SIZE_N - gi*(gi-1)/2 + (gj-gi);
      assign prod[K] = bus.in_sample[gi] * bus.in_sample[gj];
    end
    for (genvar gj = 0; gj < SIZE_N; gj++) begin : g_out
      assign bus.cov_mat[gi][gj] = cov_reg[gi][gj];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ACCUM;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ACCUM:   if (last_accept) state_next = FINAL;
      FINAL:   if (last_write)  state_next = DONE;
      DONE:    if (bus.cov_ack) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    accepting = 1'b0;
    holding   = 1'b0;
    unique case (state_reg)
      ACCUM:   accepting = 1'b1;
      DONE:    holding   = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = accepting;
  assign bus.cov_valid = holding;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt_reg <= '0;
      for (int i = 0; i < SIZE_N; i++) sum_reg[i] <= '0;
      for (int k = 0; k < NUM_T; k++)  sq_reg[k]  <= '0;
    end else if (accept) begin
      cnt_reg <= cnt_reg + LOG2_M'(1);
      for (int i = 0; i < SIZE_N; i++)
        sum_reg[i] <= sum_reg[i] + {{LOG2_M{bus.in_sample[i][DATA_W-1]}}, bus.in_sample[i]};
      for (int k = 0; k < NUM_T; k++)
        sq_reg[k] <= sq_reg[k] + {{(ACC_W-2*DATA_W){prod[k][2*DATA_W-1]}}, prod[k]};
    end
  end

  // Issue one element per cycle, then operand register and product register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k_reg   <= '0;
      row_reg <= '0;
      col_reg <= '0;
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
    end else begin
      v1_reg <= 1'b0;
      if (state_reg != FINAL) begin
        k_reg   <= '0;
        row_reg <= '0;
        col_reg <= '0;
      end else if (k_reg != K_W'(NUM_T)) begin
        v1_reg    <= 1'b1;
        a1_reg    <= sum_reg[row_reg];
        b1_reg    <= sum_reg[col_reg];
        sq1_reg   <= sq_reg[k_reg];
        row1_reg  <= row_reg;
        col1_reg  <= col_reg;
        last1_reg <= (k_reg == K_W'(NUM_T-1));
        k_reg     <= k_reg + K_W'(1);
        if (col_reg == IDX_W'(SIZE_N-1)) begin
          row_reg <= row_reg + IDX_W'(1);
          col_reg <= row_reg + IDX_W'(1);
        end else begin
          col_reg <= col_reg + IDX_W'(1);
        end
      end
      v2_reg    <= v1_reg;
      prod2_reg <= a1_reg * b1_reg;
      sq2_reg   <= sq1_reg;
      row2_reg  <= row1_reg;
      col2_reg  <= col1_reg;
      last2_reg <= last1_reg;
    end
  end

  // The true difference always fits ACC_W, so modular subtraction on the low
  // bits is exact even when the second-moment sum itself has wrapped.
  always_comb begin
    corr    = prod2_reg >>> LOG2_M;
    diff    = sq2_reg - corr[ACC_W-1:0];
    cov_val = diff >>> LOG2_M;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SIZE_N; i++)
        for (int j = 0; j < SIZE_N; j++)
          cov_reg[i][j] <= '0;
    end else if (v2_reg) begin
      cov_reg[row2_reg][col2_reg] <= cov_val;
      cov_reg[col2_reg][row2_reg] <= cov_val;
    end
  end
endmodule

// File: tb/tb_covariance_accumulator.sv
// Directed-vector bench for covariance_accumulator: M=4 instance for the main
// scenarios plus an M=1024 instance for full-scale extreme values.
module tb_covariance_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic signed [63:0] exp_m [8][8];

  covariance_accumulator_if #(.SIZE_N(8), .DATA_W(24), .LOG2_M(2))  bus ();
  covariance_accumulator_if #(.SIZE_N(8), .DATA_W(24), .LOG2_M(10)) bus10 ();

  covariance_accumulator #(.SIZE_N(8), .DATA_W(24), .LOG2_M(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  covariance_accumulator #(.SIZE_N(8), .DATA_W(24), .LOG2_M(10)) dut10 (
    .clk(clk), .rst(rst), .bus(bus10)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_exp(input logic signed [63:0] a, b, c, d);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        exp_m[i][j] = d;
    exp_m[0][0] = a;
    exp_m[0][1] = b;
    exp_m[1][0] = b;
    exp_m[1][1] = c;
  endtask

  task automatic check_mat(input string tag);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), bus.cov_mat[i][j], exp_m[i][j]);
    $display("frame %s checked", tag);
  endtask

  task automatic send(input int v0, v1, vr, gap, output int waits);
    waits = 0;
    bus.in_sample[0] = 24'(v0);
    bus.in_sample[1] = 24'(v1);
    for (int i = 2; i < 8; i++) bus.in_sample[i] = 24'(vr);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 100) check("send_timeout", waits, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // mode 0: constant vectors, 1: sign alternates, 2: only the first vector nonzero
  task automatic frame(input int mode, p, q, r, gap, output int first_wait);
    int w;
    first_wait = 0;
    for (int k = 0; k < 4; k++) begin
      if (mode == 2 && k > 0)           send(0, 0, 0, (k < 3) ? gap : 0, w);
      else if (mode == 1 && k % 2 == 1) send(-p, -q, -r, (k < 3) ? gap : 0, w);
      else                              send(p, q, r, (k < 3) ? gap : 0, w);
      if (k == 0) first_wait = w;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    check({tag, "_ready_low"}, bus.in_ready, 0);
    while (!bus.cov_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 38);
  endtask

  task automatic ack();
    bus.cov_ack = 1'b1;
    @(posedge clk); #1;
    bus.cov_ack = 1'b0;
    check("ack_valid_low", bus.cov_valid, 0);
    check("ack_ready_high", bus.in_ready, 1);
  endtask

  task automatic frame10(input int alt, input int v, input logic signed [63:0] expv, input string tag);
    int n = 0;
    check({tag, "_ready"}, bus10.in_ready, 1);
    bus10.in_valid = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      for (int i = 0; i < 8; i++) bus10.in_sample[i] = (alt != 0 && k % 2 == 1) ? 24'(-v) : 24'(v);
      @(posedge clk); #1;
    end
    bus10.in_valid = 1'b0;
    while (!bus10.cov_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 38);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), bus10.cov_mat[i][j], expv);
    bus10.cov_ack = 1'b1;
    @(posedge clk); #1;
    bus10.cov_ack = 1'b0;
    check({tag, "_ack"}, bus10.cov_valid, 0);
    $display("frame %s checked", tag);
  endtask

  initial begin
    int w, bad;
    bus.in_valid = 1'b0;  bus.cov_ack = 1'b0;
    bus10.in_valid = 1'b0; bus10.cov_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_sample[i] = '0;
      bus10.in_sample[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.in_ready, 1);
    check("rst_valid", bus.cov_valid, 0);
    check("rst_mat00", bus.cov_mat[0][0], 0);
    check("rst_mat75", bus.cov_mat[7][5], 0);
    check("rst10_ready", bus10.in_ready, 1);
    rst = 1'b1;

    frame(0, 0, 0, 0, 0, w);
    wait_valid("zero");
    set_exp(0, 0, 0, 0);
    check_mat("zero");
    bad = 0;
    repeat (5) begin @(posedge clk); #1; if (bus.cov_valid !== 1'b1) bad++; end
    check("zero_valid_held", bad, 0);
    ack();

    frame(1, 1000, 2000, 0, 0, w);
    wait_valid("alt");
    set_exp(1000000, 2000000, 4000000, 0);
    check_mat("alt");
    ack();

    frame(0, 5, 5, 5, 0, w);
    wait_valid("const5");
    set_exp(0, 0, 0, 0);
    check_mat("const5");
    ack();

    frame(1, 1000, 2000, 0, 3, w);
    wait_valid("gaps");
    set_exp(1000000, 2000000, 4000000, 0);
    check_mat("gaps");
    ack();

    frame(2, 3, -3, 0, 0, w);
    wait_valid("floor");
    set_exp(1, -2, 1, 0);
    check_mat("floor");
    ack();

    frame(0, -8388608, -8388608, -8388608, 0, w);
    wait_valid("minval");
    set_exp(0, 0, 0, 0);
    check_mat("minval");
    ack();

    frame(1, 8388607, 8388607, 8388607, 0, w);
    wait_valid("maxalt");
    set_exp(64'sd70368727400449, 64'sd70368727400449, 64'sd70368727400449, 64'sd70368727400449);
    check_mat("maxalt");
    ack();

    send(7777, 7777, 7777, 0, w);
    send(7777, 7777, 7777, 0, w);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst_ready", bus.in_ready, 1);
    frame(1, 1000, 2000, 0, 0, w);
    wait_valid("midrst");
    set_exp(1000000, 2000000, 4000000, 0);
    check_mat("midrst");
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("donerst_valid", bus.cov_valid, 0);
    check("donerst_mat01", bus.cov_mat[0][1], 0);

    frame(1, 1000, 2000, 0, 0, w);
    wait_valid("hold");
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.in_ready !== 1'b0 || bus.cov_valid !== 1'b1 || bus.cov_mat[1][0] !== 49'sd2000000) bad++;
    end
    check("hold_50_stable", bad, 0);
    check_mat("hold");
    ack();
    frame(2, 3, -3, 0, 0, w);
    check("ack_to_accept_wait", w, 0);
    wait_valid("after_ack");
    set_exp(1, -2, 1, 0);
    check_mat("after_ack");
    ack();

    frame10(0, -8388608, 0, "m1024_min");
    frame10(1, 8388607, 64'sd70368727400449, "m1024_alt");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/covariance_accumulator.md
# covariance_accumulator

Streaming front end of the PCA/ICA path. It accepts multichannel ECG sample vectors one per cycle and accumulates first and second moments over a fixed frame of 2**LOG2_M vectors. It then produces the mean-removed, normalised SIZE_N x SIZE_N covariance matrix that feeds the eigenvalue decomposition stage. The matrix is held stable under a valid/ack handshake so the downstream stage can latch it as its input.

## Interface
- SIZE_N, 8: number of channels; matrix dimension.
- DATA_W, 24: signed sample width.
- LOG2_M, 10: log2 of the frame length; M = 2**LOG2_M vectors per frame.
- ACC_W (localparam), 2*DATA_W + LOG2_M - 1 = 57: signed second-moment accumulator and output width.
- SUM_W (localparam), DATA_W + LOG2_M: signed first-moment accumulator width.
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-low reset.
- in_valid, in, 1: in_sample holds a valid vector.
- in_ready, out, 1: block can accept a vector this cycle.
- in_sample, in, [SIZE_N] x DATA_W signed: one sample per channel.
- cov_valid, out, 1: cov_mat is complete and stable.
- cov_ack, in, 1: downstream has consumed cov_mat.
- cov_mat, out, [SIZE_N][SIZE_N] x ACC_W signed: covariance matrix, symmetric.

## Operation
- Handshake: a vector is accepted on any cycle where in_valid && in_ready. Gaps in in_valid are allowed and do not count toward the frame.
- States:
  - ACCUM: in_ready=1.
    - Each accepted vector adds x_i to s_i for every channel i.
    - It adds x_i*x_j to S_ij for every i<=j, giving N(N+1)/2 parallel products.
    - A sample counter of LOG2_M bits increments per accepted vector.
    - Acceptance with counter = M-1 moves the state to FINAL and wraps the counter to 0.
  - FINAL: in_ready=0.
    - One upper-triangular element is processed per cycle, row-major (i=0..N-1, j=i..N-1), through one pipelined multiplier with 2 stages.
    - Each element computes C_ij = (S_ij - ((s_i*s_j) >>> LOG2_M)) >>> LOG2_M, using full-precision 2*SUM_W intermediates.
    - The result is written to cov_mat[i][j] and cov_mat[j][i].
    - After the last write, the state moves to DONE.
  - DONE: in_ready=0, cov_valid=1, and cov_mat is frozen.
    - cov_ack moves the state to ACCUM and clears all s_i, S_ij, and the counter.
    - cov_mat keeps its value until overwritten in the next FINAL.
- Arithmetic:
  - All arithmetic is two's complement.
  - >>> is an arithmetic shift, so results round toward minus infinity.
  - No saturation: widths guarantee no overflow for any input within DATA_W.
- cov_ack outside DONE is ignored.
- in_valid outside ACCUM is ignored, because in_ready=0.

## Timing
- Reset (rst=0 at an edge) gives:
  - state ACCUM
  - in_ready=1
  - cov_valid=0
  - cov_mat all zeros
  - all accumulators and the counter at 0
- Reset mid-frame or mid-FINAL discards all partial results. There is no output pulse.
- Reset in DONE drops cov_valid on the next cycle.
- Latency:
  - The last vector of a frame is accepted at edge T.
  - in_ready is 0 from T+1.
  - cov_valid rises after edge T + N(N+1)/2 + 2. For N=8, that is T+38.
- cov_ack sampled high at edge A in DONE gives:
  - cov_valid=0 and in_ready=1 after A.
  - The first vector of the next frame can be accepted at A+1.
- Throughput is M accepted vectors plus N(N+1)/2 + 3 cycles per frame, plus ack wait.

## Test plan
All scenarios use SIZE_N=8, DATA_W=24, LOG2_M=2 (M=4) unless noted.
- Reset then four all-zero vectors:
  - cov_valid rises 38 cycles after the 4th acceptance.
  - cov_mat is all 0.
  - cov_valid stays high until cov_ack.
- Constant 5 on all channels for 4 vectors: every cov_mat element = 0, since (100 - (400>>>2))>>>2 = 0.
- Channel 0 = +1000,-1000,+1000,-1000; channel 1 = 2x channel 0; others 0:
  - cov[0][0]=1_000_000.
  - cov[0][1]=cov[1][0]=2_000_000.
  - cov[1][1]=4_000_000.
  - All other elements 0.
- Same stimulus with in_valid deasserted for 3 cycles between each vector: results identical, and the counter counts only accepted vectors.
- Extreme values with LOG2_M=10: all channels at -2**23 for 1024 vectors gives all elements 0 with no overflow. Alternating ±(2**23-1) gives each element (2**23-1)**2.
- Two scenarios on reset and ack:
  - Assert rst=0 after 2 of 4 vectors, then feed a fresh 4-vector frame: the result equals the fresh frame alone.
  - Hold cov_ack=0 for 50 cycles in DONE: cov_mat is stable and in_ready=0 throughout. The next frame starts the cycle after the ack.
